// File: rtl/seq_det_101_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_101_pkg
// Shared constants for the "101" serial pattern detector.
//   STATE_W : width of the state register
//   IDLE    : no progress toward a match
//   GOT_1   : a leading '1' has been seen
//   GOT_10  : "10" has been seen; a '1' now completes the pattern
// Optional build macro used by the detector: SEQ_DET_101_NO_OVERLAP_EN
// -----------------------------------------------------------------------------
package seq_det_101_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t GOT_1  = 2'd1;
    localparam state_t GOT_10 = 2'd2;

endpackage : seq_det_101_pkg

// File: rtl/seq_det_101.sv
// -----------------------------------------------------------------------------
// seq_det_101
// Mealy detector that flags the serial sequence 1-0-1 on i_a, one bit per
// rising edge of i_clk. By default matches may overlap: the final '1' of one
// match is reused as the first '1' of the next.
//
// Build option:
//   SEQ_DET_101_NO_OVERLAP_EN - when defined, a completed match returns to
//                               idle so its trailing '1' is not reused.
//
// Ports:
//   i_clk      in   1        clock, rising edge active
//   i_rst      in   1        synchronous active-high reset
//   i_a        in   1        serial data bit
//   o_y        out  1        detection flag (combinational Mealy output)
//   pres_state out  STATE_W  current registered state (debug/coverage)
//   next_state out  STATE_W  combinational next state (debug/coverage)
// -----------------------------------------------------------------------------
module seq_det_101
    import seq_det_101_pkg::*;
#(
    parameter state_t idle   = IDLE,
    parameter state_t got_1  = GOT_1,
    parameter state_t got_10 = GOT_10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_a,
    output logic               o_y,
    output logic [STATE_W-1:0] pres_state,
    output logic [STATE_W-1:0] next_state
);

    // State register: reset to idle, otherwise follow the computed next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pres_state <= idle;
        end else begin
            pres_state <= next_state;
        end
    end

    // Next-state and Mealy output decode; reset and unused encodings fall to idle.
    always_comb begin
        next_state = idle;
        o_y        = 1'b0;
        if (i_rst) begin
            next_state = idle;
            o_y        = 1'b0;
        end else begin
            case (pres_state)
                idle: begin
                    if (i_a) begin
                        next_state = got_1;
                    end else begin
                        next_state = idle;
                    end
                end
                got_1: begin
                    if (i_a) begin
                        next_state = got_1;
                    end else begin
                        next_state = got_10;
                    end
                end
                got_10: begin
                    if (i_a) begin
                        o_y = 1'b1;
`ifdef SEQ_DET_101_NO_OVERLAP_EN
                        // Match consumed entirely; the next one needs a fresh '1'.
                        next_state = idle;
`else
                        // Trailing '1' doubles as the start of the next match.
                        next_state = got_1;
`endif
                    end else begin
                        next_state = idle;
                    end
                end
                default: begin
                    next_state = idle;
                    o_y        = 1'b0;
                end
            endcase
        end
    end

endmodule : seq_det_101

// File: tb/tb_seq_det_101.sv
// -----------------------------------------------------------------------------
// tb_seq_det_101
// Directed bench for seq_det_101. Inputs change on the falling clock edge;
// outputs are checked 1 time unit later, well before the next rising edge.
// Expected values are hand-derived from the 1-0-1 state diagram.
// -----------------------------------------------------------------------------
module tb_seq_det_101;

`ifdef SEQ_DET_101_NO_OVERLAP_EN
    localparam bit NOOV = 1'b1;
`else
    localparam bit NOOV = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_a;
    logic       o_y;
    logic [1:0] pres_state;
    logic [1:0] next_state;

    int checks = 0;
    int errors = 0;

    seq_det_101 dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_a        (i_a),
        .o_y        (o_y),
        .pres_state (pres_state),
        .next_state (next_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_outs(input logic [1:0] ep, input logic [1:0] en,
                              input logic ey, input string tag);
        checks++;
        assert (pres_state === ep) else begin
            errors++;
            $error("FAIL %s pres_state got %0d expected %0d", tag, pres_state, ep);
        end
        checks++;
        assert (next_state === en) else begin
            errors++;
            $error("FAIL %s next_state got %0d expected %0d", tag, next_state, en);
        end
        checks++;
        assert (o_y === ey) else begin
            errors++;
            $error("FAIL %s o_y got %0b expected %0b", tag, o_y, ey);
        end
    endtask

    // Present one bit on the falling edge and check outputs during that bit.
    task automatic step(input logic a, input logic r, input logic [1:0] ep,
                        input logic [1:0] en, input logic ey, input string tag);
        @(negedge i_clk);
        i_a   = a;
        i_rst = r;
        #1;
        check_outs(ep, en, ey, tag);
    endtask

    initial begin
        i_rst = 1'b1;
        i_a   = 1'b0;
        repeat (2) @(posedge i_clk);

        // 1. reset holds idle regardless of i_a
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, "rst_a1");
        step(1'b0, 1'b1, 2'd0, 2'd0, 1'b0, "rst_a0");
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, "rst_a1b");
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, "rel_0");
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, "rel_1");

        // 2. single match 0,1,0,1,0
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, "one_b1");
        step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "one_b2");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "one_b3");
        step(1'b1, 1'b0, 2'd2, 2'd1, 1'b1, "one_b4");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "one_b5");
        step(1'b0, 1'b0, 2'd2, 2'd0, 1'b0, "one_flush");

        // 3. overlap 0,1,0,1,0,1,0,1,0,1
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, "ovl_b1");
        step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "ovl_b2");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "ovl_b3");
        step(1'b1, 1'b0, 2'd2, NOOV ? 2'd0 : 2'd1, 1'b1, "ovl_b4");
        step(1'b0, 1'b0, NOOV ? 2'd0 : 2'd1, NOOV ? 2'd0 : 2'd2, 1'b0, "ovl_b5");
        step(1'b1, 1'b0, NOOV ? 2'd0 : 2'd2, 2'd1, NOOV ? 1'b0 : 1'b1, "ovl_b6");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "ovl_b7");
        step(1'b1, 1'b0, 2'd2, NOOV ? 2'd0 : 2'd1, 1'b1, "ovl_b8");
        step(1'b0, 1'b0, NOOV ? 2'd0 : 2'd1, NOOV ? 2'd0 : 2'd2, 1'b0, "ovl_b9");
        step(1'b1, 1'b0, NOOV ? 2'd0 : 2'd2, 2'd1, NOOV ? 1'b0 : 1'b1, "ovl_b10");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "ovl_fl1");
        step(1'b0, 1'b0, 2'd2, 2'd0, 1'b0, "ovl_fl2");

        // 4. non-matching stream 1,1,0,0,1,1
        step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "nm_b1");
        step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, "nm_b2");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "nm_b3");
        step(1'b0, 1'b0, 2'd2, 2'd0, 1'b0, "nm_b4");
        step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "nm_b5");
        step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, "nm_b6");

        // 5. reset in the middle of a match
        step(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, "mid_b1");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "mid_b2");
        step(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, "mid_rst");
        step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "mid_after");
        step(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, "mid_next");

        // 6. illegal encoding forced into the state register
        @(negedge i_clk);
        force dut.pres_state = 2'd3;
        i_a = 1'b0;
        #1;
        check_outs(2'd3, 2'd0, 1'b0, "ill_a0");
        i_a = 1'b1;
        #1;
        check_outs(2'd3, 2'd0, 1'b0, "ill_a1");
        release dut.pres_state;
        step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, "ill_recover");
        step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "ill_resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_det_101

// File: doc/seq_det_101.md
Name: seq_det_101

Overview:
- Serial bit-stream pattern detector that flags the sequence "1-0-1" on a single-bit input, sampled once per clock.
- Mealy finite-state machine with three states and overlapping detection.
- Exposes its present/next state for debug and coverage.
- Used as a leaf utility wherever a serial line must be watched for the 101 marker.

Parameters:
- idle, 2'd0, encoding of the reset/no-progress state.
- got_1, 2'd1, encoding of the state entered after a '1' has been seen.
- got_10, 2'd2, encoding of the state entered after "10" has been seen.
- Requirement: the three values are distinct and fit in 2 bits. Encoding 2'd3 is never assigned by the parameters.

Ports:
- i_clk  input  1  clock; all state updates occur on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_a  input  1  serial data bit, sampled on each rising i_clk.
- o_y  output  1  detection flag; combinational Mealy output.
- pres_state  output  2  current registered state.
- next_state  output  2  combinational next state.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high. On a rising i_clk with i_rst=1, pres_state <= idle.
  - While i_rst=1, next_state is forced to idle and o_y is forced to 0 combinationally.
  - Mid-operation reset discards any partial match; detection restarts from idle after reset deasserts.
- State register: pres_state <= next_state on every rising i_clk when i_rst=0.
- Transitions (overlapping):
  - idle: i_a=1 -> got_1; i_a=0 -> idle.
  - got_1: i_a=0 -> got_10; i_a=1 -> got_1.
  - got_10: i_a=1 -> got_1 (trailing '1' reused as start of next match); i_a=0 -> idle.
  - Any unused encoding (2'd3 under default parameters) -> idle, with o_y=0.
- Output:
  - o_y = 1 exactly when pres_state==got_10 and i_a==1 (and i_rst==0); otherwise 0.
  - Zero-cycle latency: o_y asserts in the same cycle the final '1' is presented, before the clock edge that consumes it.
  - o_y lasts one cycle per detection, assuming i_a is stable within the cycle.
- Output validity: o_y, next_state and pres_state are glitch-tolerant combinational/registered values. Consumers sample them on the rising i_clk.
- Back-to-back patterns: input "10101" produces two o_y pulses (on the 3rd and 5th bits).

Optional Feature:
- Macro: SEQ_DET_101_NO_OVERLAP_EN.
- Defined: from got_10 with i_a=1, next_state=idle, so the trailing '1' is not reused. "10101" yields one pulse (3rd bit) and "101101" yields two.
- Undefined (default): overlapping behaviour exactly as described under Behaviour.
- o_y timing is identical in both builds.

Decomposition:
- Package seq_det_101_pkg holds:
  - state width localparam STATE_W = 2;
  - the default encodings IDLE=2'd0, GOT_1=2'd1, GOT_10=2'd2.
- The module parameter defaults reference these package constants.
- No sub-module: one state register process, one next-state/output combinational process.

Test Plan:
- Drive i_a on the falling edge of i_clk.
1. Reset: i_rst=1 for 2 cycles with i_a toggling -> pres_state==0, next_state==0, o_y==0 throughout; after release, pres_state stays 0 while i_a=0.
2. Single match: i_a = 0,1,0,1,0 -> pres_state 0,1,2,1,2. o_y=1 only during the 4th bit (pres_state==2, i_a==1).
3. Overlap: i_a = 0,1,0,1,0,1,0,1,0,1 -> o_y pulses on the 4th, 6th, 8th and 10th bits (4 pulses). With SEQ_DET_101_NO_OVERLAP_EN: pulses on the 4th and 8th bits only.
4. Non-matches: i_a = 1,1,0,0,1,1 -> states 1,1,2,0,1,1; o_y never asserts.
5. Reset mid-match: i_a = 1,0, then i_rst=1 for one edge with i_a=1, then i_a=1 -> o_y=0 during reset; pres_state==0 after reset, then 1; no pulse.
6. Illegal state: force pres_state=2'd3 for one cycle -> next_state==0 and o_y==0 for i_a=0 and i_a=1; recovers to idle on the next edge.
